// File: rtl/ring_osc_edge_counter.sv
// rtl/ring_osc_edge_counter.sv - ring oscillator edge counter over a programmable clk window
// Optional continuous measurement mode: define MEASDLY_CONT_EN.
module ring_osc_edge_counter #(
    parameter int CNT_W     = 16,
    parameter int GATE_BASE = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       osc_in,
    input  logic       start,
    input  logic [1:0] gate_sel,
    input  logic       byte_sel,
    output logic [7:0] count_out,
    output logic       busy,
    output logic       done,
    output logic       ovf
);

    localparam int TW = $clog2(GATE_BASE) + 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, GATE, HOLD} state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] result;
    logic [TW-1:0]    timer;
    logic             osc_s1, osc_s2, osc_s3;
    logic             st_s1, st_s2, st_s3;
`ifdef MEASDLY_CONT_EN
    logic             win_ovf;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            osc_s1 <= 1'b0;
            osc_s2 <= 1'b0;
            osc_s3 <= 1'b0;
            // Start chain resets high so a switch already on at release is not a new edge.
            st_s1  <= 1'b1;
            st_s2  <= 1'b1;
            st_s3  <= 1'b1;
        end else begin
            osc_s1 <= osc_in;
            osc_s2 <= osc_s1;
            osc_s3 <= osc_s2;
            st_s1  <= start;
            st_s2  <= st_s1;
            st_s3  <= st_s2;
        end
    end

    logic             osc_edge;
    logic             start_pe;
    logic             at_max;
    logic             hit;
    logic             last;
    logic [CNT_W-1:0] count_next;
    logic [TW-1:0]    window_len;

    assign osc_edge   = osc_s2 & ~osc_s3;
    assign start_pe   = st_s2 & ~st_s3;
    assign at_max     = (counter == CNT_MAX);
    assign hit        = osc_edge & at_max;
    assign count_next = (osc_edge && !at_max) ? counter + 1'b1 : counter;
    assign last       = (timer == TW'(1));
    assign window_len = TW'(GATE_BASE) << gate_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            counter <= '0;
            result  <= '0;
            timer   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
`ifdef MEASDLY_CONT_EN
            win_ovf <= 1'b0;
`endif
        end else begin
`ifdef MEASDLY_CONT_EN
            case (state)
                IDLE: begin
                    if (start_pe) begin
                        state   <= GATE;
                        counter <= '0;
                        timer   <= window_len;
                        busy    <= 1'b1;
                        win_ovf <= 1'b0;
                    end
                end
                GATE: begin
                    done <= 1'b0;
                    if (last) begin
                        // Window end and reload share one cycle so no edge is lost.
                        result  <= count_next;
                        ovf     <= win_ovf | hit;
                        win_ovf <= 1'b0;
                        counter <= '0;
                        timer   <= window_len;
                        done    <= 1'b1;
                    end else begin
                        counter <= count_next;
                        win_ovf <= win_ovf | hit;
                        timer   <= timer - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
`else
            case (state)
                IDLE, HOLD: begin
                    if (start_pe) begin
                        state   <= GATE;
                        counter <= '0;
                        timer   <= window_len;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        ovf     <= 1'b0;
                    end
                end
                GATE: begin
                    counter <= count_next;
                    if (hit)
                        ovf <= 1'b1;
                    if (last) begin
                        state  <= HOLD;
                        result <= count_next;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
`endif
        end
    end

    logic [15:0] result_wide;
    assign result_wide = 16'(result);
    assign count_out   = byte_sel ? result_wide[15:8] : result_wide[7:0];

endmodule
